instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Program-counter and instruction-fetch stage of the 8-bit CPU, sitting directly upstream of control_unit. It holds the PC, requests 32-bit instruction words from instruction memory/cache with a busywait handshake, and latches each word into an instruction register. It presents the decoded OPCODE and operand fields to control_unit and the register file. It then selects the next PC from control_unit's JUMP/BRANCH outputs and the ALU ZERO flag.

## Interface
- PC_RESET, 32'd0, PC value loaded on reset
- OFFSET_SHIFT, 2, left shift applied to the signed 8-bit jump/branch offset (word addressing)
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- INSTR_READDATA  in  32  instruction word from instruction memory
- INSTR_BUSYWAIT  in  1  high while instruction memory has not completed the read
- DATA_BUSYWAIT  in  1  high while the current instruction's data-memory access is stalling
- JUMP  in  1  from control_unit
- BRANCH  in  1  from control_unit
- ZERO  in  1  ALU zero flag for the current instruction
- PC  out  32  address of the instruction being fetched/executed
- INSTR_READ  out  1  read request to instruction memory
- INSTR_VALID  out  1  instruction register holds the instruction now executing
- OPCODE  out  8  IR[31:24]
- RD  out  3  IR[18:16], destination register
- RT  out  3  IR[10:8], source register 1
- RS  out  3  IR[2:0], source register 2
- IMMEDIATE  out  8  IR[7:0]
- OFFSET  out  8  IR[23:16], signed jump/branch offset
- RETIRED  out  16  count of completed instructions

## Operation
- FSM states: IDLE, FETCH, ISSUE.
- IDLE: entered on reset. It lasts exactly one cycle and then moves to FETCH.
- FETCH: INSTR_READ=1, address = PC.
  - On an edge with INSTR_BUSYWAIT=0: IR <= INSTR_READDATA, go to ISSUE.
  - Otherwise remain in FETCH with the request held.
- ISSUE: INSTR_VALID=1, INSTR_READ=0. Decoded fields are driven combinationally from IR and stay stable for the whole state.
  - On an edge with DATA_BUSYWAIT=0: PC <= next_pc, RETIRED <= RETIRED+1, go to FETCH.
  - Otherwise hold every output.
- next_pc, sampled at the completing edge of ISSUE:
  - JUMP=1, BRANCH=0: taken.
  - JUMP=0, BRANCH=1: taken if ZERO=1 (beq).
  - JUMP=1, BRANCH=1: taken if ZERO=0 (bne).
  - JUMP=0, BRANCH=0: not taken.
  - Not taken: PC+4.
  - Taken: PC+4 + (sign_extend_32(OFFSET) << OFFSET_SHIFT).
- Arithmetic: all 32-bit unsigned modulo 2^32. PC wraps silently at both 32'hFFFFFFFC+4 and underflow below 0.
- INSTR_BUSYWAIT is ignored outside FETCH, and DATA_BUSYWAIT is ignored outside ISSUE.
- RETIRED wraps from 16'hFFFF to 0.
- Decode outputs: in IDLE and FETCH they show the previous IR contents, which is zero after reset. Consumers must qualify them with INSTR_VALID.

## Timing
- Reset, applied asynchronously and held until deassertion:
  - State=IDLE, PC=PC_RESET, IR=0, RETIRED=0.
  - INSTR_READ=0, INSTR_VALID=0, and all decode fields 0.
- The first INSTR_READ rises 1 cycle after reset is released.
- Minimum instruction period is 2 cycles (FETCH 1 + ISSUE 1). Each cycle of INSTR_BUSYWAIT or DATA_BUSYWAIT adds exactly one cycle.
- The PC update and the rise of INSTR_READ happen on the same edge, so the new fetch address is visible immediately in FETCH.
- Reset mid-FETCH or mid-ISSUE:
  - INSTR_READ and INSTR_VALID drop within the reset assertion, with no clock needed.
  - No PC update and no RETIRED increment occur.
  - An in-flight memory response is discarded.
- JUMP, BRANCH and ZERO may carry control_unit/ALU settling delay. They must be stable before the completing edge of ISSUE and are not sampled at any other time.

## Test plan
- Reset and zero wait: release RESET, memory returns 32'h00_02_00_05 (loadi r2,5) with no busywait.
  - IDLE for 1 cycle, then INSTR_READ=1 with PC=0.
  - Next cycle INSTR_VALID=1, OPCODE=0, RD=2, IMMEDIATE=5.
  - Next edge PC=4, RETIRED=1.
- Fetch stall: INSTR_BUSYWAIT held high for 3 cycles at PC=8.
  - INSTR_READ stays 1 and PC stays 8 for 4 cycles.
  - IR captures only on the edge where busywait is low.
- Jump backward: PC=16, OFFSET=8'hFC, JUMP=1, BRANCH=0 -> next PC = 20 + (-16) = 4.
- Branches at PC=0, OFFSET=8'h03:
  - beq (BRANCH=1) with ZERO=1 -> PC=16; with ZERO=0 -> PC=4.
  - bne (JUMP=1, BRANCH=1) with ZERO=0 -> PC=16; with ZERO=1 -> PC=4.
- Data stall plus wrap: PC_RESET=32'hFFFFFFFC, DATA_BUSYWAIT high for 2 ISSUE cycles.
  - Outputs held for 3 ISSUE cycles, then PC=0 and RETIRED=1.
- Reset mid-operation: assert RESET in ISSUE with PC=40 and RETIRED=7.
  - Without a clock edge: PC=0, RETIRED=0, INSTR_VALID=0, INSTR_READ=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// PC and instruction-fetch stage: fetches 32-bit words with a busywait handshake,
// latches them into IR, exposes decoded fields and selects the next PC from JUMP/BRANCH/ZERO.
module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET     = 32'd0,
    parameter int unsigned OFFSET_SHIFT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR_READDATA,
    input  logic        INSTR_BUSYWAIT,
    input  logic        DATA_BUSYWAIT,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        ZERO,
    output logic [31:0] PC,
    output logic        INSTR_READ,
    output logic        INSTR_VALID,
    output logic [7:0]  OPCODE,
    output logic [2:0]  RD,
    output logic [2:0]  RT,
    output logic [2:0]  RS,
    output logic [7:0]  IMMEDIATE,
    output logic [7:0]  OFFSET,
    output logic [15:0] RETIRED
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [15:0] retired_q;
    logic        instr_read_q;
    logic        instr_valid_q;

    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] offset_ext;
    logic [31:0] next_pc;

    // JUMP+BRANCH together encode bne; BRANCH alone is beq.
    always_comb begin
        taken = 1'b0;
        unique case ({JUMP, BRANCH})
            2'b10:   taken = 1'b1;
            2'b01:   taken = ZERO;
            2'b11:   taken = ~ZERO;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        offset_ext = {{24{ir_q[23]}}, ir_q[23:16]} << OFFSET_SHIFT;
        next_pc    = taken ? (pc_plus4 + offset_ext) : pc_plus4;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            pc_q          <= PC_RESET;
            ir_q          <= 32'd0;
            retired_q     <= 16'd0;
            instr_read_q  <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q      <= StFetch;
                    instr_read_q <= 1'b1;
                end
                StFetch: begin
                    if (!INSTR_BUSYWAIT) begin
                        ir_q          <= INSTR_READDATA;
                        state_q       <= StIssue;
                        instr_read_q  <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                StIssue: begin
                    // PC update and the next fetch request share this edge.
                    if (!DATA_BUSYWAIT) begin
                        pc_q          <= next_pc;
                        retired_q     <= retired_q + 16'd1;
                        state_q       <= StFetch;
                        instr_read_q  <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    instr_read_q  <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[15:11];

    assign PC          = pc_q;
    assign INSTR_READ  = instr_read_q;
    assign INSTR_VALID = instr_valid_q;
    assign RETIRED     = retired_q;
    assign OPCODE      = ir_q[31:24];
    assign OFFSET      = ir_q[23:16];
    assign RD          = ir_q[18:16];
    assign RT          = ir_q[10:8];
    assign RS          = ir_q[2:0];
    assign IMMEDIATE   = ir_q[7:0];

endmodule
